// File: rtl/lbp_hist_pkg.sv
// lbp_pkg: shared definitions for the LBP histogram block.
//   - default widths for the LBP result port and bin counters
//   - NUM_BINS (one bin per LBP code)
//   - state_t: controller states ACCUM/DRAIN/DUMP/DONE
//   - sat_inc(): saturating increment used for bin counts and pixel total
package lbp_pkg;

  localparam int unsigned ADDR_W_DEF = 14;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned CNT_W_DEF  = 15;
  localparam int unsigned NUM_BINS   = 2 ** DATA_W_DEF;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    DUMP  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Increment v by one, holding at max_v.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/lbp_hist_ram.sv
// lbp_hist_ram: 2**DATA_W x CNT_W bin store.
//   clk, reset : clock, asynchronous active-high clear of all bins and read data
//   rd_addr    : read address, sampled on the rising edge
//   rd_data    : registered read data
//   we, wr_addr, wr_data : synchronous write port
// A read of the address being written on the same edge returns the new value,
// so a pixel two slots behind an update of the same bin sees the fresh count.
module lbp_hist_ram
  import lbp_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] rd_addr,
  output logic [CNT_W-1:0]  rd_data,
  input  logic              we,
  input  logic [DATA_W-1:0] wr_addr,
  input  logic [CNT_W-1:0]  wr_data
);

  localparam int unsigned DEPTH = 2 ** DATA_W;

  logic [CNT_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_data <= '0;
    end else begin
      if (we) begin
        mem[wr_addr] <= wr_data;
      end
      rd_data <= (we && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
    end
  end

endmodule

// File: rtl/lbp_hist.sv
// lbp_hist: snoops the LBP result write port and builds a histogram of LBP
// codes; on finish it streams every bin over a valid/ready port, clearing
// each bin as it is accepted, then pulses hist_done and returns to ACCUM.
//   clk, reset          : clock, asynchronous active-high reset
//   lbp_valid/addr/data : LBP result strobe, pixel address, code (= bin index)
//   finish              : frame complete
//   busy                : high in DRAIN/DUMP/DONE; lbp_valid ignored then
//   hist_valid/ready    : dump beat handshake
//   hist_bin/count      : bin index and its count for the current beat
//   hist_total          : pixels accumulated this frame
//   hist_done           : one-cycle pulse after the last bin is accepted
// Build option: LBP_HIST_BORDER_SKIP_EN drops pixels on the image border
// (row or column 0 or IMG_W-1) from both the bins and the total.
module lbp_hist
  import lbp_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned IMG_W  = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lbp_valid,
  input  logic [ADDR_W-1:0] lbp_addr,
  input  logic [DATA_W-1:0] lbp_data,
  input  logic              finish,
  output logic              busy,
  output logic              hist_valid,
  input  logic              hist_ready,
  output logic [DATA_W-1:0] hist_bin,
  output logic [CNT_W-1:0]  hist_count,
  output logic [ADDR_W:0]   hist_total,
  output logic              hist_done
);

  localparam int unsigned       TOT_W    = ADDR_W + 1;
  localparam logic [31:0]       CNT_MAX  = 32'((64'd1 << CNT_W) - 64'd1);
  localparam logic [31:0]       TOT_MAX  = 32'((64'd1 << TOT_W) - 64'd1);
  localparam logic [DATA_W-1:0] LAST_BIN = '1;
  localparam logic [ADDR_W-1:0] IMG_W_A  = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] IMG_LAST = ADDR_W'(IMG_W - 1);
`ifdef LBP_HIST_BORDER_SKIP_EN
  localparam bit SKIP_BORDER = 1'b1;
`else
  localparam bit SKIP_BORDER = 1'b0;
`endif

  state_t state;
  logic   drain_cnt;

  logic              s0_valid, s1_valid, s2_valid;
  logic [DATA_W-1:0] s0_bin, s1_bin, s2_bin;
  logic [CNT_W-1:0]  s2_wdata;
  logic [CNT_W-1:0]  s1_cnt;

  logic [DATA_W-1:0] idx;
  logic              beat_valid;
  logic [TOT_W-1:0]  total;

  logic [ADDR_W-1:0] pix_row, pix_col;
  logic              on_border, accept, beat_take;

  logic [DATA_W-1:0] rd_addr, wr_addr;
  logic [CNT_W-1:0]  rd_data, wr_data;
  logic              we;

  assign pix_row   = lbp_addr / IMG_W_A;
  assign pix_col   = lbp_addr % IMG_W_A;
  assign on_border = (pix_row == '0) || (pix_row == IMG_LAST) ||
                     (pix_col == '0) || (pix_col == IMG_LAST);
  assign accept    = (state == ACCUM) && lbp_valid && !(SKIP_BORDER && on_border);
  assign beat_take = (state == DUMP) && beat_valid && hist_ready;

  // The S2 write lands on the same edge S1 would otherwise consume stale data.
  assign s1_cnt = (s2_valid && (s2_bin == s1_bin)) ? s2_wdata : rd_data;

  always_comb begin
    rd_addr = s0_bin;
    wr_addr = s2_bin;
    wr_data = s2_wdata;
    we      = s2_valid;
    if (state == DUMP) begin
      // Prefetch the next bin on acceptance so ready-high dumps one bin per cycle.
      rd_addr = beat_take ? idx + DATA_W'(1) : idx;
      if (!s2_valid) begin
        wr_addr = idx;
        wr_data = '0;
        we      = beat_take;
      end
    end
  end

  lbp_hist_ram #(
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) u_ram (
    .clk    (clk),
    .reset  (reset),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .we     (we),
    .wr_addr(wr_addr),
    .wr_data(wr_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ACCUM;
      drain_cnt  <= 1'b0;
      s0_valid   <= 1'b0;
      s0_bin     <= '0;
      s1_valid   <= 1'b0;
      s1_bin     <= '0;
      s2_valid   <= 1'b0;
      s2_bin     <= '0;
      s2_wdata   <= '0;
      idx        <= '0;
      beat_valid <= 1'b0;
      total      <= '0;
    end else begin
      s0_valid <= accept;
      if (accept) begin
        s0_bin <= lbp_data;
        total  <= TOT_W'(sat_inc(32'(total), TOT_MAX));
      end
      s1_valid <= s0_valid;
      s1_bin   <= s0_bin;
      s2_valid <= s1_valid;
      s2_bin   <= s1_bin;
      s2_wdata <= CNT_W'(sat_inc(32'(s1_cnt), CNT_MAX));

      case (state)
        ACCUM: begin
          if (finish) begin
            state     <= DRAIN;
            drain_cnt <= 1'b0;
          end
        end
        DRAIN: begin
          if (drain_cnt) begin
            state      <= DUMP;
            idx        <= '0;
            beat_valid <= 1'b0;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        DUMP: begin
          if (!beat_valid) begin
            beat_valid <= 1'b1;
          end else if (hist_ready) begin
            idx <= idx + DATA_W'(1);
            if (idx == LAST_BIN) begin
              state      <= DONE;
              beat_valid <= 1'b0;
            end
          end
        end
        DONE: begin
          total <= '0;
          state <= ACCUM;
        end
        default: state <= ACCUM;
      endcase
    end
  end

  assign busy       = (state != ACCUM);
  assign hist_valid = beat_valid;
  assign hist_bin   = idx;
  assign hist_count = beat_valid ? rd_data : '0;
  assign hist_total = total;
  assign hist_done  = (state == DONE);

endmodule
